// File: rtl/biu_pkg.sv
// Shared types for the bus interface unit: bus-cycle states and bus operation kinds.
package biu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        TW   = 3'd4,
        T4   = 3'd5
    } biu_state_e;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_EU_RD = 2'd1,
        OP_EU_WR = 2'd2
    } biu_op_e;

endpackage

// File: rtl/bus_interface_unit_if.sv
// EU request/ack, prefetch queue and external bus signals of the BIU.
// eu_req is held by the EU until it sees the one-cycle eu_ack pulse; q_pop consumes the head on the next edge.
interface bus_interface_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 20
);
    logic              eu_req;
    logic              eu_we;
    logic [ADDR_W-1:0] eu_addr;
    logic [DATA_W-1:0] eu_wdata;
    logic              eu_ack;
    logic [DATA_W-1:0] eu_rdata;
    logic              q_pop;
    logic              q_valid;
    logic [DATA_W-1:0] q_data;
    logic              flush;
    logic [ADDR_W-1:0] flush_addr;
    logic [ADDR_W-1:0] Direction;
    logic              ale;
    logic              RD_WR;
    logic [DATA_W-1:0] Data_out;
    logic              Data_oe;
    logic [DATA_W-1:0] Data_in;
    logic              ready;

    modport slave (
        input  eu_req, eu_we, eu_addr, eu_wdata, q_pop, flush, flush_addr, Data_in, ready,
        output eu_ack, eu_rdata, q_valid, q_data, Direction, ale, RD_WR, Data_out, Data_oe
    );

    modport master (
        output eu_req, eu_we, eu_addr, eu_wdata, q_pop, flush, flush_addr, Data_in, ready,
        input  eu_ack, eu_rdata, q_valid, q_data, Direction, ale, RD_WR, Data_out, Data_oe
    );
endinterface

// File: rtl/biu_prefetch_fifo.sv
// Circular prefetch queue; clear wins over push/pop, and a pop on an empty queue is ignored.
module biu_prefetch_fifo #(
    parameter  int DATA_W = 8,
    parameter  int QDEPTH = 4,
    localparam int CNT_W  = $clog2(QDEPTH + 1),
    localparam int PTR_W  = $clog2(QDEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [QDEPTH];
    logic [PTR_W-1:0]  rd_q;
    logic [PTR_W-1:0]  wr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(QDEPTH)) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) rd_q <= ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/bus_interface_unit.sv
// 8088-style BIU: T1-T4 bus cycles with READY wait states, EU accesses prioritised over
// background instruction prefetch into a QDEPTH-entry queue.
module bus_interface_unit
    import biu_pkg::*;
#(
    parameter  int                DATA_W   = 8,
    parameter  int                ADDR_W   = 20,
    parameter  int                QDEPTH   = 4,
    parameter  logic [ADDR_W-1:0] RESET_IP = 20'hFFFF0,
    localparam int                CNT_W    = $clog2(QDEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_interface_unit_if.slave     bus,
    output biu_state_e              dbg_state_o,
    output logic [CNT_W-1:0]        dbg_count_o
);

    biu_state_e        state_q;
    biu_op_e           op_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] dir_q;
    logic [DATA_W-1:0] wdata_q, cap_q, data_out_q, eu_rdata_q;
    logic              ale_q, rd_wr_q, data_oe_q, eu_ack_q, discard_q;

    logic              q_push, q_pop_eff, eu_start, fetch_start;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W:0]    cnt_nxt;
    logic [DATA_W-1:0] q_head;

    // A fetch flushed while on the bus still completes, but its byte is dropped.
    assign q_push    = (state_q == T4) && (op_q == OP_FETCH) && !discard_q && !bus.flush;
    assign q_pop_eff = bus.q_pop && (q_count != '0);
    assign cnt_nxt   = {1'b0, q_count} + {{CNT_W{1'b0}}, q_push} - {{CNT_W{1'b0}}, q_pop_eff};
    assign ptr_d     = bus.flush ? bus.flush_addr : (q_push ? ptr_q + ADDR_W'(1) : ptr_q);

    // The EU still holds eu_req during the T4 that acks it, so that request is not re-granted.
    assign eu_start    = bus.eu_req && !((state_q == T4) && (op_q != OP_FETCH));
    assign fetch_start = bus.flush || (cnt_nxt < (CNT_W + 1)'(QDEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_FETCH;
            ptr_q      <= RESET_IP;
            dir_q      <= '0;
            wdata_q    <= '0;
            cap_q      <= '0;
            data_out_q <= '0;
            eu_rdata_q <= '0;
            ale_q      <= 1'b0;
            rd_wr_q    <= 1'b0;
            data_oe_q  <= 1'b0;
            eu_ack_q   <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            eu_ack_q <= 1'b0;
            ale_q    <= 1'b0;
            case (state_q)
                IDLE, T4: begin
                    discard_q  <= 1'b0;
                    data_oe_q  <= 1'b0;
                    data_out_q <= '0;
                    if (eu_start) begin
                        state_q <= T1;
                        op_q    <= bus.eu_we ? OP_EU_WR : OP_EU_RD;
                        wdata_q <= bus.eu_wdata;
                        dir_q   <= bus.eu_addr;
                        rd_wr_q <= bus.eu_we;
                        ale_q   <= 1'b1;
                    end else if (fetch_start) begin
                        state_q <= T1;
                        op_q    <= OP_FETCH;
                        dir_q   <= ptr_d;
                        rd_wr_q <= 1'b0;
                        ale_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        dir_q   <= '0;
                        rd_wr_q <= 1'b0;
                    end
                end
                T1: begin
                    state_q <= T2;
                    if (op_q == OP_EU_WR) begin
                        data_oe_q  <= 1'b1;
                        data_out_q <= wdata_q;
                    end
                end
                T2: state_q <= T3;
                T3, TW: begin
                    if (bus.ready) begin
                        state_q <= T4;
                        cap_q   <= bus.Data_in;
                        if (op_q != OP_FETCH) eu_ack_q   <= 1'b1;
                        if (op_q == OP_EU_RD) eu_rdata_q <= bus.Data_in;
                    end else begin
                        state_q <= TW;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (bus.flush && (op_q == OP_FETCH) && (state_q inside {T1, T2, T3, TW}))
                discard_q <= 1'b1;
        end
    end

    biu_prefetch_fifo #(
        .DATA_W (DATA_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (q_push),
        .push_data_i (cap_q),
        .pop_i       (bus.q_pop),
        .clear_i     (bus.flush),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    assign bus.Direction = dir_q;
    assign bus.ale       = ale_q;
    assign bus.RD_WR     = rd_wr_q;
    assign bus.Data_out  = data_out_q;
    assign bus.Data_oe   = data_oe_q;
    assign bus.eu_ack    = eu_ack_q;
    assign bus.eu_rdata  = eu_rdata_q;
    assign bus.q_valid   = (q_count != '0);
    assign bus.q_data    = q_head;
    assign dbg_state_o   = state_q;
    assign dbg_count_o   = q_count;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed bench for bus_interface_unit; memory returns Direction[7:0] ^ 8'h5A unless overridden.
module tb_bus_interface_unit;
    import biu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    biu_state_e dbg_state;
    logic [2:0] dbg_count;
    logic       din_force;
    logic [7:0] din_val;
    int         errors = 0;
    int         checks = 0;

    bus_interface_unit_if #(.DATA_W(8), .ADDR_W(20)) bif();

    bus_interface_unit #(
        .DATA_W(8), .ADDR_W(20), .QDEPTH(4), .RESET_IP(20'hFFFF0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bif.slave),
        .dbg_state_o (dbg_state),
        .dbg_count_o (dbg_count)
    );

    always #5 clk = ~clk;

    assign bif.Data_in = din_force ? din_val : (bif.Direction[7:0] ^ 8'h5A);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dbg_state !== IDLE && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL %s_idle_timeout state=%0d required=%0d", tag, dbg_state, IDLE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.eu_req = 0; bif.eu_we = 0; bif.eu_addr = '0; bif.eu_wdata = '0;
        bif.q_pop = 0; bif.flush = 0; bif.flush_addr = '0; bif.ready = 1;
        din_force = 0; din_val = '0;
        step(); step();
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", dbg_count); end
        checks++; if ({bif.ale, bif.RD_WR, bif.Data_oe, bif.eu_ack, bif.q_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {bif.ale, bif.RD_WR, bif.Data_oe, bif.eu_ack, bif.q_valid});
        end
        checks++; if (bif.Direction !== 20'h0) begin errors++; $display("FAIL reset_dir got=%h exp=00000", bif.Direction); end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        logic [7:0] exp_head;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (dbg_state !== T1) begin errors++; $display("FAIL fill_t1 k=%0d got=%0d exp=%0d", k, dbg_state, T1); end
            checks++; if (bif.Direction !== 20'hFFFF0 + 20'(k)) begin errors++; $display("FAIL fill_dir k=%0d got=%h exp=%h", k, bif.Direction, 20'hFFFF0 + 20'(k)); end
            checks++; if (bif.ale !== 1'b1 || bif.RD_WR !== 1'b0) begin errors++; $display("FAIL fill_ale k=%0d ale=%b rdwr=%b exp=1,0", k, bif.ale, bif.RD_WR); end
            checks++; if (dbg_count !== 3'(k)) begin errors++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, dbg_count, k); end
            step(); step(); step();
            checks++; if (dbg_state !== T4 || bif.ale !== 1'b0) begin errors++; $display("FAIL fill_t4 k=%0d state=%0d ale=%b exp=%0d,0", k, dbg_state, bif.ale, T4); end
        end
        step();
        exp_head = 8'hAA;
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL fill_idle got=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if (dbg_count !== 3'd4 || bif.q_valid !== 1'b1) begin errors++; $display("FAIL fill_full count=%0d valid=%b exp=4,1", dbg_count, bif.q_valid); end
        checks++; if (bif.q_data !== exp_head) begin errors++; $display("FAIL fill_head got=%h exp=%h", bif.q_data, exp_head); end
    endtask

    task automatic test_eu_read();
        biu_state_e exp_st [6] = '{T1, T2, T3, TW, TW, T4};
        bif.eu_req = 1; bif.eu_we = 0; bif.eu_addr = 20'h01234;
        din_force = 1; din_val = 8'hA5; bif.ready = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (dbg_state !== exp_st[i]) begin errors++; $display("FAIL rd_state cyc=%0d got=%0d exp=%0d", i + 1, dbg_state, exp_st[i]); end
            checks++; if (bif.eu_ack !== (i == 5)) begin errors++; $display("FAIL rd_ack cyc=%0d got=%b exp=%b", i + 1, bif.eu_ack, i == 5); end
            if (i == 0) begin
                checks++; if (bif.Direction !== 20'h01234) begin errors++; $display("FAIL rd_dir got=%h exp=01234", bif.Direction); end
            end
            bif.ready = (i >= 4);
        end
        checks++; if (bif.eu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got=%h exp=a5", bif.eu_rdata); end
        bif.eu_req = 0; din_force = 0; bif.ready = 1;
        step();
        checks++; if (dbg_state !== IDLE || bif.eu_ack !== 1'b0) begin errors++; $display("FAIL rd_after state=%0d ack=%b exp=%0d,0", dbg_state, bif.eu_ack, IDLE); end
        checks++; if (bif.eu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_hold got=%h exp=a5", bif.eu_rdata); end
    endtask

    task automatic test_eu_write();
        bif.q_pop = 1;
        step();
        bif.q_pop = 0;
        checks++; if (dbg_state !== T1 || bif.Direction !== 20'hFFFF4) begin errors++; $display("FAIL wr_fetch state=%0d dir=%h exp=%0d,ffff4", dbg_state, bif.Direction, T1); end
        checks++; if (dbg_count !== 3'd3 || bif.q_data !== 8'hAB) begin errors++; $display("FAIL wr_pop count=%0d head=%h exp=3,ab", dbg_count, bif.q_data); end
        step();
        bif.eu_req = 1; bif.eu_we = 1; bif.eu_addr = 20'h00010; bif.eu_wdata = 8'h3C;
        step(); step();
        checks++; if (dbg_state !== T4 || bif.RD_WR !== 1'b0) begin errors++; $display("FAIL wr_fetch_t4 state=%0d rdwr=%b exp=%0d,0", dbg_state, bif.RD_WR, T4); end
        step();
        checks++; if (dbg_state !== T1 || bif.Direction !== 20'h00010) begin errors++; $display("FAIL wr_t1 state=%0d dir=%h exp=%0d,00010", dbg_state, bif.Direction, T1); end
        checks++; if (bif.RD_WR !== 1'b1 || bif.ale !== 1'b1 || bif.Data_oe !== 1'b0) begin errors++; $display("FAIL wr_t1_ctl rdwr=%b ale=%b oe=%b exp=1,1,0", bif.RD_WR, bif.ale, bif.Data_oe); end
        checks++; if (dbg_count !== 3'd4) begin errors++; $display("FAIL wr_push count=%0d exp=4", dbg_count); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bif.Data_oe !== 1'b1 || bif.Data_out !== 8'h3C) begin errors++; $display("FAIL wr_drive cyc=%0d oe=%b dout=%h exp=1,3c", i, bif.Data_oe, bif.Data_out); end
        end
        checks++; if (bif.eu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", bif.eu_ack); end
        bif.eu_req = 0; bif.eu_we = 0;
        step();
        checks++; if (dbg_state !== IDLE || bif.Data_oe !== 1'b0) begin errors++; $display("FAIL wr_end state=%0d oe=%b exp=%0d,0", dbg_state, bif.Data_oe, IDLE); end
        checks++; if (bif.q_data !== 8'hAB || bif.eu_rdata !== 8'hA5) begin errors++; $display("FAIL wr_end_data head=%h rdata=%h exp=ab,a5", bif.q_data, bif.eu_rdata); end
    endtask

    task automatic test_flush();
        bif.q_pop = 1;
        step();
        bif.q_pop = 0;
        checks++; if (bif.Direction !== 20'hFFFF5) begin errors++; $display("FAIL fl_fetch_dir got=%h exp=ffff5", bif.Direction); end
        step(); step();
        bif.flush = 1; bif.flush_addr = 20'h00100;
        step();
        bif.flush = 0;
        checks++; if (dbg_state !== T4 || bif.q_valid !== 1'b0) begin errors++; $display("FAIL fl_clear state=%0d valid=%b exp=%0d,0", dbg_state, bif.q_valid, T4); end
        step();
        checks++; if (dbg_state !== T1 || bif.Direction !== 20'h00100) begin errors++; $display("FAIL fl_newdir state=%0d dir=%h exp=%0d,00100", dbg_state, bif.Direction, T1); end
        checks++; if (bif.q_valid !== 1'b0) begin errors++; $display("FAIL fl_discard valid=%b exp=0", bif.q_valid); end
        step(); step(); step(); step();
        checks++; if (bif.Direction !== 20'h00101 || bif.q_data !== 8'h5A || dbg_count !== 3'd1) begin
            errors++; $display("FAIL fl_second dir=%h head=%h count=%0d exp=00101,5a,1", bif.Direction, bif.q_data, dbg_count);
        end
        wait_idle("fl");
        checks++; if (dbg_count !== 3'd4 || bif.q_data !== 8'h5A) begin errors++; $display("FAIL fl_full count=%0d head=%h exp=4,5a", dbg_count, bif.q_data); end
    endtask

    task automatic test_flush_wrap();
        bif.flush = 1; bif.flush_addr = 20'hFFFFF;
        step();
        bif.flush = 0;
        checks++; if (bif.Direction !== 20'hFFFFF || dbg_count !== 3'd0) begin errors++; $display("FAIL wrap_first dir=%h count=%0d exp=fffff,0", bif.Direction, dbg_count); end
        step(); step(); step(); step();
        checks++; if (bif.Direction !== 20'h00000 || dbg_state !== T1) begin errors++; $display("FAIL wrap_zero dir=%h state=%0d exp=00000,%0d", bif.Direction, dbg_state, T1); end
        checks++; if (bif.q_data !== 8'hA5 || dbg_count !== 3'd1) begin errors++; $display("FAIL wrap_head head=%h count=%0d exp=a5,1", bif.q_data, dbg_count); end
        wait_idle("wrap");
        checks++; if (dbg_count !== 3'd4 || bif.q_data !== 8'hA5) begin errors++; $display("FAIL wrap_full count=%0d head=%h exp=4,a5", dbg_count, bif.q_data); end
    endtask

    task automatic test_back_to_back();
        bif.q_pop = 1;
        step();
        bif.q_pop = 0;
        checks++; if (bif.Direction !== 20'h00003 || bif.q_data !== 8'h5A) begin errors++; $display("FAIL b2b_start dir=%h head=%h exp=00003,5a", bif.Direction, bif.q_data); end
        step(); step(); step();
        checks++; if (dbg_state !== T4 || dbg_count !== 3'd3) begin errors++; $display("FAIL b2b_t4 state=%0d count=%0d exp=%0d,3", dbg_state, dbg_count, T4); end
        bif.q_pop = 1;
        step();
        bif.q_pop = 0;
        checks++; if (dbg_count !== 3'd3 || bif.q_data !== 8'h5B) begin errors++; $display("FAIL b2b_pushpop count=%0d head=%h exp=3,5b", dbg_count, bif.q_data); end
        checks++; if (dbg_state !== T1 || bif.Direction !== 20'h00004) begin errors++; $display("FAIL b2b_next state=%0d dir=%h exp=%0d,00004", dbg_state, bif.Direction, T1); end
        wait_idle("b2b");
        bif.q_pop = 1;
        step();
        checks++; if (bif.q_data !== 8'h58 || dbg_count !== 3'd3) begin errors++; $display("FAIL b2b_pop1 head=%h count=%0d exp=58,3", bif.q_data, dbg_count); end
        step();
        checks++; if (bif.q_data !== 8'h59 || dbg_count !== 3'd2) begin errors++; $display("FAIL b2b_tail head=%h count=%0d exp=59,2", bif.q_data, dbg_count); end
        step();
        bif.q_pop = 0;
        checks++; if (bif.q_data !== 8'h5E || dbg_count !== 3'd1) begin errors++; $display("FAIL b2b_pop3 head=%h count=%0d exp=5e,1", bif.q_data, dbg_count); end
        wait_idle("b2b_end");
    endtask

    task automatic test_reset_midcycle();
        bif.q_pop = 1;
        step();
        bif.q_pop = 0;
        step();
        reset = 1'b1;
        #1;
        checks++; if (dbg_state !== IDLE || dbg_count !== 3'd0) begin errors++; $display("FAIL mid_reset state=%0d count=%0d exp=%0d,0", dbg_state, dbg_count, IDLE); end
        checks++; if (bif.Direction !== 20'h0 || bif.ale !== 1'b0 || bif.q_valid !== 1'b0 || bif.eu_rdata !== 8'h00) begin
            errors++; $display("FAIL mid_reset_out dir=%h ale=%b valid=%b rdata=%h exp=00000,0,0,00", bif.Direction, bif.ale, bif.q_valid, bif.eu_rdata);
        end
        step();
        reset = 1'b0;
        step();
        checks++; if (dbg_state !== T1 || bif.Direction !== 20'hFFFF0) begin errors++; $display("FAIL mid_restart state=%0d dir=%h exp=%0d,ffff0", dbg_state, bif.Direction, T1); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_eu_read();
        test_eu_write();
        test_flush();
        test_flush_wrap();
        test_back_to_back();
        test_reset_midcycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_interface_unit.md
# bus_interface_unit

Parametrised 8088-style bus interface unit: runs T1–T4 bus cycles with READY-driven wait states, and keeps a QDEPTH-entry instruction prefetch queue filled in the background. Execution-unit (EU) memory reads and writes take priority over prefetch. It sits between the execution core and the external memory bus, replacing the fixed-width, queue-less interface of the current top.

## Interface
Parameters:
- DATA_W, 8, bus and queue data width
- ADDR_W, 20, address width
- QDEPTH, 4, prefetch queue entries (≥2)
- RESET_IP, 20'hFFFF0, fetch pointer after reset (ADDR_W bits)

Ports (one clock, clk; reset is asynchronous and active-high, named reset):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- eu_req  in  1  EU bus request, held until eu_ack
- eu_we  in  1  1 = write, 0 = read
- eu_addr  in  ADDR_W  EU address
- eu_wdata  in  DATA_W  EU write data
- eu_ack  out  1  one-cycle completion pulse
- eu_rdata  out  DATA_W  read data, valid with eu_ack, held until next EU read
- q_pop  in  1  consume queue head
- q_valid  out  1  queue non-empty
- q_data  out  DATA_W  queue head
- flush  in  1  discard queue, reload fetch pointer
- flush_addr  in  ADDR_W  new fetch pointer
- Direction  out  ADDR_W  bus address
- ale  out  1  address latch enable
- RD_WR  out  1  1 = write cycle, 0 = read cycle
- Data_out  out  DATA_W  write data
- Data_oe  out  1  Data_out drive enable
- Data_in  in  DATA_W  read data from bus
- ready  in  1  memory ready, sampled in T3/TW

## Operation
- FSM states: IDLE, T1, T2, T3, TW, T4.
  - T1: Direction = cycle address, ale = 1.
  - T2: RD_WR valid; on writes Data_oe = 1 and Data_out = data (T2–T4).
  - T3/TW: ready = 0 → TW; ready = 1 → capture Data_in and go to T4.
  - T4: EU cycle pulses eu_ack; fetch cycle pushes captured byte into queue and increments fetch pointer.
- Arbitration in IDLE and T4. Pick the first that applies:
  1. eu_req → EU cycle.
  2. Queue count < QDEPTH → fetch at fetch pointer.
  3. Otherwise go to IDLE.
- A new cycle from T4 goes straight to T1. There is no idle cycle between back-to-back cycles.
- EU request fields are sampled at the arbitration point and must remain stable until eu_ack.
- Fetch pointer increments modulo 2^ADDR_W (all-ones wraps to 0).
- Queue: circular buffer; q_data = head, q_valid = (count ≠ 0).
  - Pop when empty is ignored.
  - Push and pop in the same cycle leave count unchanged.
- Flush: next cycle count = 0, fetch pointer = flush_addr.
  - An in-flight fetch completes on the bus, but its data is discarded and the pointer is not incremented.
  - An in-flight EU cycle is unaffected.
  - Flush beats a simultaneous pop or push.
- Reset (any time, including mid-cycle): state IDLE, count 0, fetch pointer RESET_IP, all outputs 0.

## Timing
- EU request seen in IDLE at cycle 0: T1 at 1, T2 at 2, T3 at 3, eu_ack at 4 with zero wait states. Each low-ready sample adds one cycle.
- The bus cycle always takes at least 4 clocks, and ale is high for exactly one clock per cycle.
- q_valid rises the cycle after the T4 that fills an empty queue.
- q_pop takes effect on the next edge.
- Max idle-to-full: QDEPTH × 4 cycles with ready tied high.

## Structure
- biu_pkg: state enum typedef (IDLE..T4), bus-op enum (OP_FETCH, OP_EU_RD, OP_EU_WR).
- Sub-module biu_prefetch_fifo (DATA_W, QDEPTH): push, pop, clear, head, count of width $clog2(QDEPTH+1).
- The FSM, arbiter and fetch pointer live in bus_interface_unit.

## Test plan
- Reset, ready = 1, no pops → fetches at FFFF0, FFFF1, FFFF2, FFFF3, each 4 cycles. Then IDLE, count = 4, q_data = byte from FFFF0.
- EU read of 0x01234 with ready low for 2 samples, Data_in = 8'hA5 → states T1 T2 T3 TW TW T4, eu_ack at cycle 6, eu_rdata = A5.
- EU write 0x00010, data 8'h3C, raised during a fetch's T2 → fetch finishes. Next cycle T1 with Direction = 0x00010, RD_WR = 1, Data_oe high T2–T4, Data_out = 3C.
- Flush to 0x00100 during a fetch's T3 → q_valid = 0 next cycle, that fetched byte is never visible, next fetch Direction = 0x00100.
- Flush to 0xFFFFF → fetches at 0xFFFFF then 0x00000.
- Queue at count 3, pop in the same cycle as T4 push → count stays 3. The head advances and the new byte lands at the tail.
